// File: rtl/reg_ctx_pkg.sv
// Shared definitions for the register-context sequencer.
// Holds the sizing constants, the FSM state encoding, the save-word payload
// and a saturating index helper used by the top.
// Optional feature macro: REG_CTX_CKSUM_EN (checksum word on save/restore).
package reg_ctx_pkg;

  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IDX_W     = 3;
  // Word index needs one extra bit so the checksum slot (NUM_REGS) fits.
  localparam int unsigned CNT_W     = IDX_W + 1;
  localparam int unsigned CKSUM_IDX = NUM_REGS;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_RD,
    SAVE_CAP,
    SAVE_PUSH,
    RESTORE,
    FINISH
  } ctx_state_t;

  // One outbound save word: slot index plus payload.
  typedef struct packed {
    logic [CNT_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } save_word_t;

  // Advance a word index, holding at the checksum slot so it never wraps.
  function automatic logic [CNT_W-1:0] idx_inc(input logic [CNT_W-1:0] idx);
    return (idx >= CNT_W'(CKSUM_IDX)) ? idx : idx + CNT_W'(1);
  endfunction

endpackage

// File: rtl/reg_ctx_cksum.sv
// XOR accumulator for context checksums.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          zero the accumulator (takes priority over en)
//   en, din      fold din into the accumulator
//   cmp          word compared against the current accumulator
//   sum          registered accumulator value
//   mismatch_c   combinational: sum != cmp
// Instantiated only when REG_CTX_CKSUM_EN is defined.
module reg_ctx_cksum
  import reg_ctx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] cmp,
  output logic [DATA_W-1:0] sum,
  output logic              mismatch_c
);

  logic [DATA_W-1:0] sum_q, sum_d;

  // Next accumulator value.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum        = sum_q;
  assign mismatch_c = (sum_q != cmp);

endmodule

// File: rtl/reg_ctx_sequencer.sv
// Whole-context save/restore sequencer for the 8x16 register file.
// Save walks R0..R7 through the SR1 read port and streams words out on a
// valid/ready memory-write interface; restore accepts a word stream and loads
// R0..R7. cpu_hold is high whenever the sequencer is not idle.
// Optional feature macro: REG_CTX_CKSUM_EN adds a trailing XOR checksum word
// to both directions and drives ckerr; without it ckerr is tied low.
// Ports:
//   Clk, Reset_al             clock, async active-low reset
//   save_req, restore_req     start requests, sampled only in IDLE
//   cpu_hold, done, ckerr     status (done is a one-cycle pulse)
//   rf_sr_sel / rf_sr_data    register-file read (data one cycle later)
//   rf_ld/rf_dr_sel/rf_d_out  register-file write (combinational in RESTORE)
//   mem_wr_*                  save word stream
//   rst_valid/ready/data      restore word stream
module reg_ctx_sequencer
  import reg_ctx_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_al,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              cpu_hold,
  output logic              done,
  output logic              ckerr,
  output logic [IDX_W-1:0]  rf_sr_sel,
  input  logic [DATA_W-1:0] rf_sr_data,
  output logic              rf_ld,
  output logic [IDX_W-1:0]  rf_dr_sel,
  output logic [DATA_W-1:0] rf_d_out,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [CNT_W-1:0]  mem_wr_idx,
  input  logic              rst_valid,
  output logic              rst_ready,
  input  logic [DATA_W-1:0] rst_data
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] NumIdx  = CNT_W'(NUM_REGS);

  ctx_state_t       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  save_word_t       wr_q, wr_d;
  logic             wr_valid_q, wr_valid_d;
  logic             done_q, done_d;
  logic             hold_q, hold_d;
  logic             ready_q, ready_d;
  logic [IDX_W-1:0] sr_sel_q, sr_sel_d;

`ifdef REG_CTX_CKSUM_EN
  localparam logic [CNT_W-1:0] CkIdx = CNT_W'(CKSUM_IDX);

  logic              ckerr_q, ckerr_d;
  logic              ck_clr, ck_en;
  logic [DATA_W-1:0] ck_din, ck_sum;
  logic              ck_bad_c;

  reg_ctx_cksum u_cksum (
    .clk        (Clk),
    .rst_n      (Reset_al),
    .clr        (ck_clr),
    .en         (ck_en),
    .din        (ck_din),
    .cmp        (rst_data),
    .sum        (ck_sum),
    .mismatch_c (ck_bad_c)
  );
`endif

  // Next-state, datapath and register-file write control.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    rf_ld     = 1'b0;
    rf_dr_sel = '0;
    rf_d_out  = '0;
`ifdef REG_CTX_CKSUM_EN
    ckerr_d   = ckerr_q;
    ck_clr    = 1'b0;
    ck_en     = 1'b0;
    ck_din    = '0;
`endif

    unique case (state_q)
      IDLE: begin
        // Save has priority; a coincident restore request is dropped.
        if (save_req || restore_req) begin
          state_d = save_req ? SAVE_RD : RESTORE;
          idx_d   = '0;
`ifdef REG_CTX_CKSUM_EN
          ck_clr  = 1'b1;
          ckerr_d = 1'b0;
`endif
        end
      end

      SAVE_RD: begin
        state_d = SAVE_CAP;
      end

      SAVE_CAP: begin
        wr_d.idx  = idx_q;
        wr_d.data = rf_sr_data;
`ifdef REG_CTX_CKSUM_EN
        ck_en     = 1'b1;
        ck_din    = rf_sr_data;
`endif
        state_d   = SAVE_PUSH;
      end

      SAVE_PUSH: begin
        if (mem_wr_ready) begin
          if (idx_q == LastIdx) begin
`ifdef REG_CTX_CKSUM_EN
            // Stay in SAVE_PUSH to present the checksum word next.
            idx_d     = idx_inc(idx_q);
            wr_d.idx  = CkIdx;
            wr_d.data = ck_sum;
`else
            state_d   = FINISH;
`endif
          end else if (idx_q < LastIdx) begin
            idx_d   = idx_inc(idx_q);
            state_d = SAVE_RD;
          end else begin
            state_d = FINISH;
          end
        end
      end

      RESTORE: begin
        if (rst_valid && ready_q) begin
          if (idx_q < NumIdx) begin
            rf_ld     = 1'b1;
            rf_dr_sel = idx_q[IDX_W-1:0];
            rf_d_out  = rst_data;
`ifdef REG_CTX_CKSUM_EN
            ck_en     = 1'b1;
            ck_din    = rst_data;
            idx_d     = idx_inc(idx_q);
`else
            if (idx_q == LastIdx) begin
              state_d = FINISH;
            end else begin
              idx_d = idx_inc(idx_q);
            end
`endif
          end else begin
            // Checksum word: compared only, never loaded.
`ifdef REG_CTX_CKSUM_EN
            ckerr_d = ck_bad_c;
`endif
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered status/handshake outputs follow the next state.
    hold_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    wr_valid_d = (state_d == SAVE_PUSH);
    ready_d    = (state_d == RESTORE);
    sr_sel_d   = ((state_d == SAVE_RD) || (state_d == SAVE_CAP)) ? idx_d[IDX_W-1:0] : '0;
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wr_q       <= '0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b0;
      ready_q    <= 1'b0;
      sr_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      sr_sel_q   <= sr_sel_d;
    end
  end

`ifdef REG_CTX_CKSUM_EN
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      ckerr_q <= 1'b0;
    end else begin
      ckerr_q <= ckerr_d;
    end
  end

  assign ckerr = ckerr_q;
`else
  assign ckerr = 1'b0;
`endif

  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign rf_sr_sel    = sr_sel_q;
  assign mem_wr_valid = wr_valid_q;
  assign mem_wr_data  = wr_q.data;
  assign mem_wr_idx   = wr_q.idx;
  assign rst_ready    = ready_q;

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Self-checking bench for reg_ctx_sequencer: scoreboard queues for save
// words and register loads, checked by a negedge monitor; the stimulus
// process checks latency, status outputs and reset behaviour.
module tb_reg_ctx_sequencer;
  import reg_ctx_pkg::*;

`ifdef REG_CTX_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_al;
  logic              save_req, restore_req;
  logic              cpu_hold, done, ckerr;
  logic [IDX_W-1:0]  rf_sr_sel;
  logic [DATA_W-1:0] rf_sr_data;
  logic              rf_ld;
  logic [IDX_W-1:0]  rf_dr_sel;
  logic [DATA_W-1:0] rf_d_out;
  logic              mem_wr_valid, mem_wr_ready;
  logic [DATA_W-1:0] mem_wr_data;
  logic [CNT_W-1:0]  mem_wr_idx;
  logic              rst_valid, rst_ready;
  logic [DATA_W-1:0] rst_data;

  reg_ctx_sequencer dut (
    .Clk          (Clk),
    .Reset_al     (Reset_al),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .ckerr        (ckerr),
    .rf_sr_sel    (rf_sr_sel),
    .rf_sr_data   (rf_sr_data),
    .rf_ld        (rf_ld),
    .rf_dr_sel    (rf_dr_sel),
    .rf_d_out     (rf_d_out),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_idx   (mem_wr_idx),
    .rst_valid    (rst_valid),
    .rst_ready    (rst_ready),
    .rst_data     (rst_data)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Register-file model: one-cycle read latency, write on rf_ld.
  logic [DATA_W-1:0] rf_mem [8];
  logic              preload_go;
  always @(posedge Clk) begin
    if (preload_go) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h1000 + 16'(i);
    end else if (rf_ld) begin
      rf_mem[rf_dr_sel] <= rf_d_out;
    end
    rf_sr_data <= rf_mem[rf_sr_sel];
  end

  // Restore word source: advances on each accepted word.
  logic [DATA_W-1:0] rst_words [16];
  logic [3:0]        rst_ptr;
  logic              rst_ptr_clr;
  always @(posedge Clk) begin
    if (rst_ptr_clr) rst_ptr <= '0;
    else if (rst_valid && rst_ready) rst_ptr <= rst_ptr + 4'd1;
  end
  assign rst_data = rst_words[rst_ptr];

  typedef struct packed {
    logic [IDX_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } ld_t;

  save_word_t        exp_wr[$];
  ld_t               exp_ld[$];
  logic [DATA_W-1:0] exp_rf [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every save handshake and every register load.
  always @(negedge Clk) begin
    if (Reset_al) begin
      if (mem_wr_valid && mem_wr_ready) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", {mem_wr_idx, mem_wr_data}, 64'h0);
        end else begin
          save_word_t w;
          w = exp_wr.pop_front();
          check("wr_word", {mem_wr_idx, mem_wr_data}, {w.idx, w.data});
        end
      end
      if (rf_ld) begin
        if (exp_ld.size() == 0) begin
          check("ld_unexpected", {rf_dr_sel, rf_d_out}, 64'h0);
        end else begin
          ld_t l;
          l = exp_ld.pop_front();
          check("ld_word", {rf_dr_sel, rf_d_out}, {l.sel, l.data});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_save();
    logic [DATA_W-1:0] x;
    save_word_t w;
    x = '0;
    for (int i = 0; i < 8; i++) begin
      w.idx  = 4'(i);
      w.data = exp_rf[i];
      exp_wr.push_back(w);
      x ^= exp_rf[i];
    end
    if (CK != 0) begin
      w.idx  = 4'd8;
      w.data = x;
      exp_wr.push_back(w);
    end
  endtask

  task automatic push_loads(input int cnt);
    ld_t l;
    for (int i = 0; i < cnt; i++) begin
      l.sel  = 3'(i);
      l.data = rst_words[i];
      exp_ld.push_back(l);
    end
  endtask

  task automatic clr_ptr();
    rst_ptr_clr = 1'b1;
    cyc();
    rst_ptr_clr = 1'b0;
  endtask

  // Present a request for one sampling edge; returns #1 after that edge.
  task automatic issue(input logic s, input logic r);
    save_req    = s;
    restore_req = r;
    cyc();
    save_req    = 1'b0;
  endtask

  int bp_cnt;
  logic rr_seen;

  // Count edges after the request edge until done; optional stall on word 3.
  task automatic wait_done(input int limit, input bit bp, output int n);
    n = 0;
    bp_cnt = 0;
    rr_seen = 1'b0;
    while (n < limit) begin
      cyc();
      n++;
      if (bp && mem_wr_valid && mem_wr_idx == 4'd3 && bp_cnt < 5) begin
        mem_wr_ready = 1'b0;
        bp_cnt++;
        check("stall_hold", {mem_wr_valid, mem_wr_idx, mem_wr_data}, {1'b1, 4'd3, 16'h1003});
      end else begin
        mem_wr_ready = 1'b1;
      end
      if (rst_ready) rr_seen = 1'b1;
      if (done) break;
    end
    if (!done) check("done_timeout", 64'(n), 64'(limit + 1));
  endtask

  int n;

  initial begin
    Reset_al     = 1'b0;
    save_req     = 1'b0;
    restore_req  = 1'b0;
    mem_wr_ready = 1'b1;
    rst_valid    = 1'b0;
    preload_go   = 1'b0;
    rst_ptr_clr  = 1'b1;
    for (int i = 0; i < 16; i++) rst_words[i] = '0;
    repeat (2) cyc();
    check("reset_outputs",
          {cpu_hold, done, ckerr, rf_sr_sel, rf_ld, rf_dr_sel, rf_d_out,
           mem_wr_valid, mem_wr_data, mem_wr_idx, rst_ready}, 64'h0);
    Reset_al    = 1'b1;
    rst_ptr_clr = 1'b0;
    preload_go  = 1'b1;
    cyc();
    preload_go  = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 16'h1000 + 16'(i);

    // Save without backpressure.
    push_save();
    issue(1'b1, 1'b0);
    check("save_hold", 64'(cpu_hold), 64'h1);
    wait_done(100, 1'b0, n);
    check("save_latency", 64'(n), 64'(24 + CK));
    check("save_ckerr", 64'(ckerr), 64'h0);
    cyc();
    check("save_done_pulse", {done, cpu_hold}, 64'h0);
    check("save_q_empty", 64'(exp_wr.size()), 64'h0);

    // Save with a 5-cycle stall on word 3.
    push_save();
    issue(1'b1, 1'b0);
    wait_done(100, 1'b1, n);
    check("bp_latency", 64'(n), 64'(29 + CK));
    check("bp_stalls", 64'(bp_cnt), 64'd5);
    cyc();
    check("bp_q_empty", 64'(exp_wr.size()), 64'h0);

    // Restore BEE0..BEE7 back-to-back.
    for (int i = 0; i < 8; i++) rst_words[i] = 16'hBEE0 + 16'(i);
    rst_words[8] = 16'h0000;
    clr_ptr();
    push_loads(8);
    rst_valid = 1'b1;
    issue(1'b0, 1'b1);
    restore_req = 1'b0;
    wait_done(100, 1'b0, n);
    rst_valid = 1'b0;
    check("restore_latency", 64'(n), 64'(8 + CK));
    check("restore_ckerr", 64'(ckerr), 64'h0);
    cyc();
    check("restore_q_empty", 64'(exp_ld.size()), 64'h0);
    check("restore_idle", {done, cpu_hold, rst_ready}, 64'h0);
    for (int i = 0; i < 8; i++) exp_rf[i] = 16'hBEE0 + 16'(i);

    // Read-back save.
    push_save();
    issue(1'b1, 1'b0);
    wait_done(100, 1'b0, n);
    check("readback_latency", 64'(n), 64'(24 + CK));
    cyc();
    check("readback_q_empty", 64'(exp_wr.size()), 64'h0);

    // Simultaneous requests: save wins, busy restore requests ignored.
    clr_ptr();
    push_save();
    rst_valid = 1'b1;
    issue(1'b1, 1'b1);
    wait_done(100, 1'b0, n);
    restore_req = 1'b0;
    check("simul_latency", 64'(n), 64'(24 + CK));
    check("simul_no_rst_ready", 64'(rr_seen), 64'h0);
    cyc();
    check("simul_idle1", {cpu_hold, rst_ready}, 64'h0);
    cyc();
    check("simul_idle2", {cpu_hold, rst_ready}, 64'h0);
    rst_valid = 1'b0;
    check("simul_q_empty", 64'(exp_wr.size()), 64'h0);

    // Reset after restore word 4: R0..R4 updated, R5..R7 untouched.
    for (int i = 0; i < 8; i++) rst_words[i] = 16'h5A00 + 16'(i);
    clr_ptr();
    push_loads(5);
    rst_valid = 1'b1;
    issue(1'b0, 1'b1);
    restore_req = 1'b0;
    repeat (5) cyc();
    Reset_al = 1'b0;
    #1;
    check("midreset_outputs",
          {cpu_hold, done, ckerr, rf_sr_sel, rf_ld, rf_dr_sel, rf_d_out,
           mem_wr_valid, mem_wr_data, mem_wr_idx, rst_ready}, 64'h0);
    rst_valid = 1'b0;
    cyc();
    Reset_al = 1'b1;
    cyc();
    check("midreset_q_empty", 64'(exp_ld.size()), 64'h0);
    for (int i = 0; i < 5; i++) exp_rf[i] = 16'h5A00 + 16'(i);
    push_save();
    issue(1'b1, 1'b0);
    wait_done(100, 1'b0, n);
    check("midreset_save_latency", 64'(n), 64'(24 + CK));
    cyc();
    check("midreset_save_q_empty", 64'(exp_wr.size()), 64'h0);

`ifdef REG_CTX_CKSUM_EN
    // Bad checksum word flags ckerr, held until the next request.
    for (int i = 0; i < 8; i++) rst_words[i] = 16'hBEE0 + 16'(i);
    rst_words[8] = 16'h0001;
    clr_ptr();
    push_loads(8);
    rst_valid = 1'b1;
    issue(1'b0, 1'b1);
    restore_req = 1'b0;
    wait_done(100, 1'b0, n);
    rst_valid = 1'b0;
    check("ck_bad_latency", 64'(n), 64'd9);
    check("ck_bad_ckerr", 64'(ckerr), 64'h1);
    repeat (3) cyc();
    check("ck_bad_held", 64'(ckerr), 64'h1);
    // Correct checksum clears it.
    rst_words[8] = 16'h0000;
    clr_ptr();
    check("ck_held_idle", 64'(ckerr), 64'h1);
    push_loads(8);
    rst_valid = 1'b1;
    issue(1'b0, 1'b1);
    restore_req = 1'b0;
    check("ck_cleared_on_req", 64'(ckerr), 64'h0);
    wait_done(100, 1'b0, n);
    rst_valid = 1'b0;
    check("ck_good_ckerr", 64'(ckerr), 64'h0);
    cyc();
    check("ck_q_empty", 64'(exp_ld.size()), 64'h0);
`endif

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_ctx_sequencer.md
Name: reg_ctx_sequencer

Overview:
- Sequences the 8x16 register file for whole-context save and restore, used on TRAP/interrupt entry/exit and by the debug console.
- Save: walks R0..R7 through the SR1 read path and streams each word to a memory-write handshake.
- Restore: accepts a word stream and writes R0..R7 through the register-file load path.
- Asserts cpu_hold while active so the datapath leaves the register file alone.

Parameters:
- NUM_REGS, 8, registers walked per operation (indices 0..NUM_REGS-1)
- DATA_W, 16, register word width
- IDX_W, 3, register index width (clog2 NUM_REGS)

Ports:
- Clk  in  1  system clock
- Reset_al  in  1  asynchronous active-low reset
- save_req  in  1  start save; sampled only in IDLE
- restore_req  in  1  start restore; sampled only in IDLE
- cpu_hold  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on operation completion
- ckerr  out  1  restore checksum mismatch (see Optional Feature)
- rf_sr_sel  out  IDX_W  register-file read select; read data returns one cycle later
- rf_sr_data  in  DATA_W  register-file read data
- rf_ld  out  1  register-file write enable
- rf_dr_sel  out  IDX_W  register-file write select
- rf_d_out  out  DATA_W  register-file write data
- mem_wr_valid  out  1  save word valid
- mem_wr_ready  in  1  memory accepts save word
- mem_wr_data  out  DATA_W  save word
- mem_wr_idx  out  IDX_W+1  word index (0..NUM_REGS, NUM_REGS = checksum slot)
- rst_valid  in  1  restore word valid
- rst_ready  out  1  sequencer accepts restore word
- rst_data  in  DATA_W  restore word

Behaviour:
- Reset (async, Reset_al low):
  - state IDLE; index 0; all outputs 0; cksum 0.
  - Reset mid-restore leaves already-written registers modified; no rollback.
- States: IDLE, SAVE_RD, SAVE_CAP, SAVE_PUSH, RESTORE, FINISH.
- IDLE:
  - save_req -> SAVE_RD with idx=0.
  - Otherwise restore_req -> RESTORE with idx=0.
  - Both high in the same cycle: save wins; the restore request is dropped.
  - Clears ckerr and cksum when either request is accepted.
- SAVE_RD: rf_sr_sel=idx for 1 cycle -> SAVE_CAP.
- SAVE_CAP: rf_sr_sel held; rf_sr_data registered into mem_wr_data; mem_wr_idx=idx; cksum^=data -> SAVE_PUSH.
- SAVE_PUSH:
  - mem_wr_valid=1; mem_wr_data/idx stable until mem_wr_ready.
  - On handshake: if idx==NUM_REGS-1 -> FINISH (or checksum word, see feature); else idx+1 and SAVE_RD.
  - Minimum 3 cycles per register; 24 cycles for 8 registers at ready=1.
- RESTORE:
  - rst_ready=1.
  - On rst_valid&rst_ready, in the same cycle (combinational): rf_ld=1, rf_dr_sel=idx, rf_d_out=rst_data.
  - Also on that handshake: cksum^=rst_data.
  - Last register -> FINISH; else idx+1.
  - Back-to-back words accepted every cycle; 8 cycles minimum.
- FINISH: done=1 for exactly 1 cycle -> IDLE; cpu_hold deasserts in the IDLE cycle.
- Register-file loads: rf_ld is never high outside RESTORE handshake cycles; save never asserts rf_ld.
- Requests while busy are ignored (not queued).
- Index counter saturates at its terminal value; it never wraps past NUM_REGS.

Optional Feature:
- Macro: REG_CTX_CKSUM_EN.
- Defined, save: after R7, emits a 9th word, mem_wr_idx=NUM_REGS, mem_wr_data = XOR of the 8 saved words, via SAVE_PUSH.
- Defined, restore: accepts a 9th word without rf_ld, compares it to the running XOR, and sets ckerr on mismatch in the FINISH cycle.
  - ckerr is held until the next accepted request.
  - Registers are already written; ckerr is advisory only.
- Undefined: 8 words only; ckerr tied 0; no checksum logic synthesised.

Decomposition:
- Shared package reg_ctx_pkg holds:
  - state enum ctx_state_t;
  - NUM_REGS, DATA_W, IDX_W constants;
  - CKSUM_IDX = NUM_REGS.
- One sub-module, reg_ctx_cksum: XOR accumulator with clear/enable/compare; instantiated only under REG_CTX_CKSUM_EN.

Test Plan:
- Save, no backpressure:
  - Stimulus: registers preloaded R0..R7 = 16'h1000+i; save_req one cycle; mem_wr_ready=1.
  - Response: 8 handshakes, idx 0..7, data 1000..1007; done exactly 24 cycles after the request cycle; rf_ld never high.
- Save with backpressure:
  - Stimulus: mem_wr_ready low 5 cycles on word 3.
  - Response: mem_wr_valid/data 16'h1003/idx 3 stable throughout; total +5 cycles.
- Restore:
  - Stimulus: rst_valid continuous, data 16'hBEE0+i.
  - Response: rf_ld on 8 consecutive cycles, dr_sel 0..7, rf_d_out matching; done next cycle; a read-back save returns BEE0..BEE7.
- Simultaneous save_req and restore_req in IDLE:
  - Response: save runs; rst_ready stays 0; restore_req asserted during busy has no effect.
- Reset mid-operation:
  - Stimulus: Reset_al low during restore after word 4.
  - Response: immediate IDLE, all outputs 0; R0..R4 updated, R5..R7 unchanged.
- REG_CTX_CKSUM_EN defined:
  - Save emits a 9th word 16'h0000 for the 1000..1007 set (XOR of 8 words).
  - Restore with a bad 9th word 16'h0001 -> ckerr=1 at done, held until the next request.
  - Correct checksum -> ckerr=0.
